equeue_param: RTL and testbench



---
 rtl/equeue_pkg.sv | 26 ++
 rtl/equeue_if.sv | 51 +++++
 rtl/equeue_entry.sv | 49 ++++
 rtl/equeue_param.sv | 155 +++++++++++++++
 tb/tb_equeue_param.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/equeue_pkg.sv
// Shared types and default widths for the parametrised issue queue.
// The occupancy width helper keeps the counter sized identically everywhere.
package equeue_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int OPW_DEF   = 4;
    localparam int TAGW_DEF  = 6;
    localparam int DATAW_DEF = 32;

    typedef struct packed {
        logic [OPW_DEF-1:0]   opcode;
        logic [TAGW_DEF-1:0]  rdtag;
        logic [TAGW_DEF-1:0]  rstag;
        logic [TAGW_DEF-1:0]  rttag;
        logic [DATAW_DEF-1:0] rsdata;
        logic [DATAW_DEF-1:0] rtdata;
        logic                 rsvalid;
        logic                 rtvalid;
        logic                 valid;
    } entry_t;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/equeue_if.sv
// Dispatch, CDB, issue and status signals of the issue queue.
// slave = the queue itself, master = the dispatch/issue side driving it.
interface equeue_if
    import equeue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int TAGW  = TAGW_DEF,
    parameter int DATAW = DATAW_DEF
);
    localparam int OCCW = occ_w(DEPTH);

    logic             flush;
    logic             dispatch_en;
    logic [OPW-1:0]   dispatch_opcode;
    logic [TAGW-1:0]  dispatch_rdtag;
    logic [TAGW-1:0]  dispatch_rstag;
    logic [TAGW-1:0]  dispatch_rttag;
    logic [DATAW-1:0] dispatch_rsdata;
    logic [DATAW-1:0] dispatch_rtdata;
    logic             dispatch_rsvalid;
    logic             dispatch_rtvalid;
    logic             dispatch_ready;
    logic             cdb_valid;
    logic [TAGW-1:0]  cdb_tag;
    logic [DATAW-1:0] cdb_data;
    logic             issue_ready;
    logic [OPW-1:0]   issue_opcode;
    logic [TAGW-1:0]  issue_rdtag;
    logic [DATAW-1:0] issue_rsdata;
    logic [DATAW-1:0] issue_rtdata;
    logic             issue_done;
    logic [OCCW-1:0]  occupancy;

    modport master (
        output flush, dispatch_en, dispatch_opcode, dispatch_rdtag, dispatch_rstag,
               dispatch_rttag, dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid,
               dispatch_rtvalid, cdb_valid, cdb_tag, cdb_data, issue_done,
        input  dispatch_ready, issue_ready, issue_opcode, issue_rdtag, issue_rsdata,
               issue_rtdata, occupancy
    );

    modport slave (
        input  flush, dispatch_en, dispatch_opcode, dispatch_rdtag, dispatch_rstag,
               dispatch_rttag, dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid,
               dispatch_rtvalid, cdb_valid, cdb_tag, cdb_data, issue_done,
        output dispatch_ready, issue_ready, issue_opcode, issue_rdtag, issue_rsdata,
               issue_rtdata, occupancy
    );

endinterface

// File: rtl/equeue_entry.sv
// One queue slot: picks hold / shift-in, then applies CDB wakeup to the chosen record.
// The same comparators serve shifted entries and freshly dispatched records.
module equeue_entry
    import equeue_pkg::*;
#(
    parameter type slot_t = entry_t,
    parameter int  TAGW   = TAGW_DEF,
    parameter int  DATAW  = DATAW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             shift_en,
    input  logic             load_en,
    input  slot_t            shift_in,
    input  logic             cdb_valid,
    input  logic [TAGW-1:0]  cdb_tag,
    input  logic [DATAW-1:0] cdb_data,
    output slot_t            slot_q
);
    slot_t src;
    slot_t slot_d;

    always_comb begin
        src    = (shift_en | load_en) ? shift_in : slot_q;
        slot_d = src;
        // Resolved operands never compare, so a reused tag cannot clobber data.
        if (src.valid && !src.rsvalid && cdb_valid && (src.rstag == cdb_tag)) begin
            slot_d.rsvalid = 1'b1;
            slot_d.rsdata  = cdb_data;
        end
        if (src.valid && !src.rtvalid && cdb_valid && (src.rttag == cdb_tag)) begin
            slot_d.rtvalid = 1'b1;
            slot_d.rtdata  = cdb_data;
        end
        if (kill) begin
            slot_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/equeue_param.sv
// Age-ordered collapsing issue queue: oldest ready entry issues, entries above it shift down.
// Optional ISSUEQ_CDB_BYPASS_EN lets a CDB hit make an entry issue in the same cycle.
module equeue_param
    import equeue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int TAGW  = TAGW_DEF,
    parameter int DATAW = DATAW_DEF
) (
    input  logic    clk,
    input  logic    reset,
    equeue_if.slave q
);
    localparam int OCCW = occ_w(DEPTH);
    localparam int SELW = $clog2(DEPTH);

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [TAGW-1:0]  rdtag;
        logic [TAGW-1:0]  rstag;
        logic [TAGW-1:0]  rttag;
        logic [DATAW-1:0] rsdata;
        logic [DATAW-1:0] rtdata;
        logic             rsvalid;
        logic             rtvalid;
        logic             valid;
    } slot_t;

    slot_t             ent_q [DEPTH];
    slot_t             shift_in [DEPTH];
    slot_t             disp_rec;
    slot_t             sel_ent;
    logic [DEPTH-1:0]  ready_vec;
    logic [DEPTH-1:0]  at_or_above;
    logic [DEPTH-1:0]  shift_en;
    logic [DEPTH-1:0]  load_en;
    logic [SELW-1:0]   sel;
    logic              any_ready;
    logic              remove;
    logic              full;
    logic              disp_acc;
    logic [OCCW-1:0]   land;
    logic [OCCW-1:0]   occ_q;
    logic [OCCW-1:0]   occ_d;
    logic [DATAW-1:0]  rsdata_out;
    logic [DATAW-1:0]  rtdata_out;

`ifdef ISSUEQ_CDB_BYPASS_EN
    logic [DEPTH-1:0]  rs_hit;
    logic [DEPTH-1:0]  rt_hit;
`endif

    assign full     = ent_q[DEPTH-1].valid;
    assign remove   = q.issue_done & any_ready;
    assign disp_acc = q.dispatch_en & q.dispatch_ready & ~q.flush;
    // Valid entries are contiguous, so the free slot after collapse is the post-removal count.
    assign land     = occ_q - OCCW'(remove);

    assign disp_rec = '{opcode:  q.dispatch_opcode,
                        rdtag:   q.dispatch_rdtag,
                        rstag:   q.dispatch_rstag,
                        rttag:   q.dispatch_rttag,
                        rsdata:  q.dispatch_rsdata,
                        rtdata:  q.dispatch_rtdata,
                        rsvalid: q.dispatch_rsvalid,
                        rtvalid: q.dispatch_rtvalid,
                        valid:   1'b1};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        slot_t upper;
        if (i == DEPTH - 1) begin : g_top
            assign upper = '0;
        end else begin : g_mid
            assign upper = ent_q[i+1];
        end

`ifdef ISSUEQ_CDB_BYPASS_EN
        assign rs_hit[i]    = q.cdb_valid & ~ent_q[i].rsvalid & (ent_q[i].rstag == q.cdb_tag);
        assign rt_hit[i]    = q.cdb_valid & ~ent_q[i].rtvalid & (ent_q[i].rttag == q.cdb_tag);
        assign ready_vec[i] = ent_q[i].valid & (ent_q[i].rsvalid | rs_hit[i])
                                             & (ent_q[i].rtvalid | rt_hit[i]);
`else
        assign ready_vec[i] = ent_q[i].valid & ent_q[i].rsvalid & ent_q[i].rtvalid;
`endif

        assign shift_en[i] = remove & at_or_above[i];
        assign load_en[i]  = disp_acc & (land == OCCW'(i));
        assign shift_in[i] = load_en[i] ? disp_rec : upper;

        equeue_entry #(
            .slot_t (slot_t),
            .TAGW   (TAGW),
            .DATAW  (DATAW)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .kill      (q.flush),
            .shift_en  (shift_en[i]),
            .load_en   (load_en[i]),
            .shift_in  (shift_in[i]),
            .cdb_valid (q.cdb_valid),
            .cdb_tag   (q.cdb_tag),
            .cdb_data  (q.cdb_data),
            .slot_q    (ent_q[i])
        );
    end

    always_comb begin
        sel         = '0;
        any_ready   = 1'b0;
        at_or_above = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_ready && ready_vec[i]) begin
                sel       = SELW'(i);
                any_ready = 1'b1;
            end
            at_or_above[i] = any_ready;
        end
    end

    always_comb begin
        sel_ent    = ent_q[sel];
        rsdata_out = sel_ent.rsdata;
        rtdata_out = sel_ent.rtdata;
`ifdef ISSUEQ_CDB_BYPASS_EN
        if (rs_hit[sel]) rsdata_out = q.cdb_data;
        if (rt_hit[sel]) rtdata_out = q.cdb_data;
`endif
    end

    always_comb begin
        occ_d = occ_q + OCCW'(disp_acc) - OCCW'(remove);
        if (q.flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign q.dispatch_ready = ~full | remove;
    assign q.issue_ready    = any_ready;
    assign q.issue_opcode   = sel_ent.opcode;
    assign q.issue_rdtag    = sel_ent.rdtag;
    assign q.issue_rsdata   = rsdata_out;
    assign q.issue_rtdata   = rtdata_out;
    assign q.occupancy      = occ_q;

endmodule

// File: tb/tb_equeue_param.sv
// Directed bench for equeue_param at default widths (DEPTH=4).
module tb_equeue_param;
    import equeue_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    equeue_if #(.DEPTH(4), .OPW(4), .TAGW(6), .DATAW(32)) q ();

    equeue_param #(.DEPTH(4), .OPW(4), .TAGW(6), .DATAW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q.flush            = 1'b0;
        q.dispatch_en      = 1'b0;
        q.dispatch_opcode  = '0;
        q.dispatch_rdtag   = '0;
        q.dispatch_rstag   = '0;
        q.dispatch_rttag   = '0;
        q.dispatch_rsdata  = '0;
        q.dispatch_rtdata  = '0;
        q.dispatch_rsvalid = 1'b0;
        q.dispatch_rtvalid = 1'b0;
        q.cdb_valid        = 1'b0;
        q.cdb_tag          = '0;
        q.cdb_data         = '0;
        q.issue_done       = 1'b0;
    endtask

    task automatic disp(input entry_t e);
        q.dispatch_en      = 1'b1;
        q.dispatch_opcode  = e.opcode;
        q.dispatch_rdtag   = e.rdtag;
        q.dispatch_rstag   = e.rstag;
        q.dispatch_rttag   = e.rttag;
        q.dispatch_rsdata  = e.rsdata;
        q.dispatch_rtdata  = e.rtdata;
        q.dispatch_rsvalid = e.rsvalid;
        q.dispatch_rtvalid = e.rtvalid;
        #1;
        chk("dispatch_protocol_ready", q.dispatch_ready, 1);
    endtask

    function automatic entry_t mk(input logic [3:0] opc, input logic [5:0] rd,
                                  input logic [5:0] rs, input logic [5:0] rt,
                                  input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic rsv, input logic rtv);
        entry_t e;
        e = '{opcode: opc, rdtag: rd, rstag: rs, rttag: rt, rsdata: rsd, rtdata: rtd,
              rsvalid: rsv, rtvalid: rtv, valid: 1'b1};
        return e;
    endfunction

    task automatic fill(input logic [5:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            disp(mk(4'(k + 1), base + 6'(k), 6'h00, 6'h00, 32'h100 + k, 32'h200 + k, 1'b1, 1'b1));
            step();
            idle();
        end
    endtask

    task automatic issue_one();
        q.issue_done = 1'b1;
        step();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_occ", q.occupancy, 0);
        chk("rst_issue_ready", q.issue_ready, 0);
        chk("rst_dispatch_ready", q.dispatch_ready, 1);
        chk("rst_rdtag", q.issue_rdtag, 0);
        chk("rst_opcode", q.issue_opcode, 0);
        chk("rst_rsdata", q.issue_rsdata, 0);
        reset = 1'b0;

        // fill four ready ops, no issue
        fill(6'h21, 4);
        chk("full_occ", q.occupancy, 4);
        chk("full_dispatch_ready", q.dispatch_ready, 0);
        chk("full_issue_ready", q.issue_ready, 1);
        chk("full_rdtag", q.issue_rdtag, 6'h21);
        chk("full_opcode", q.issue_opcode, 1);
        chk("full_rsdata", q.issue_rsdata, 32'h100);
        chk("full_rtdata", q.issue_rtdata, 32'h200);

        // full + issue + dispatch in the same cycle
        q.issue_done = 1'b1;
        disp(mk(4'd5, 6'h25, 6'h00, 6'h00, 32'h104, 32'h204, 1'b1, 1'b1));
        step();
        idle();
        chk("swap_occ", q.occupancy, 4);
        for (int k = 0; k < 4; k++) begin
            chk("swap_order_rdtag", q.issue_rdtag, 6'h22 + 6'(k));
            chk("swap_order_rsdata", q.issue_rsdata, 32'h101 + k);
            issue_one();
        end
        chk("drain_occ", q.occupancy, 0);
        chk("drain_issue_ready", q.issue_ready, 0);

        // out-of-order issue and CDB wakeup
        disp(mk(4'd1, 6'h31, 6'h05, 6'h06, 32'h0, 32'h600, 1'b0, 1'b1)); step(); idle();
        disp(mk(4'd2, 6'h32, 6'h05, 6'h07, 32'h0, 32'h700, 1'b0, 1'b1)); step(); idle();
        disp(mk(4'd3, 6'h33, 6'h08, 6'h09, 32'h800, 32'h900, 1'b1, 1'b1)); step(); idle();
        disp(mk(4'd4, 6'h34, 6'h05, 6'h0A, 32'hAAAA0000, 32'hA00, 1'b1, 1'b1)); step(); idle();
        chk("ooo_sel_rdtag", q.issue_rdtag, 6'h33);
        chk("ooo_occ", q.occupancy, 4);
        issue_one();
        chk("ooo_after_occ", q.occupancy, 3);
        chk("ooo_after_rdtag", q.issue_rdtag, 6'h34);
        chk("ooo_after_rsdata", q.issue_rsdata, 32'hAAAA0000);
        q.cdb_valid = 1'b1;
        q.cdb_tag   = 6'h05;
        q.cdb_data  = 32'hDEADBEEF;
        step();
        idle();
        chk("wake_rdtag0", q.issue_rdtag, 6'h31);
        chk("wake_rsdata0", q.issue_rsdata, 32'hDEADBEEF);
        chk("wake_rtdata0", q.issue_rtdata, 32'h600);
        chk("wake_occ", q.occupancy, 3);
        issue_one();
        chk("wake_rdtag1", q.issue_rdtag, 6'h32);
        chk("wake_rsdata1", q.issue_rsdata, 32'hDEADBEEF);
        issue_one();
        chk("stale_rdtag", q.issue_rdtag, 6'h34);
        chk("stale_rsdata", q.issue_rsdata, 32'hAAAA0000);
        issue_one();
        chk("wake_drain_occ", q.occupancy, 0);

        // dispatch-cycle CDB capture
        q.cdb_valid = 1'b1;
        q.cdb_tag   = 6'h11;
        q.cdb_data  = 32'h1234;
        disp(mk(4'd6, 6'h41, 6'h11, 6'h12, 32'h0, 32'h77, 1'b0, 1'b1));
        step();
        idle();
        chk("cap_issue_ready", q.issue_ready, 1);
        chk("cap_rdtag", q.issue_rdtag, 6'h41);
        chk("cap_rsdata", q.issue_rsdata, 32'h1234);
        chk("cap_rtdata", q.issue_rtdata, 32'h77);
        chk("cap_occ", q.occupancy, 1);
        issue_one();
        chk("cap_drain_occ", q.occupancy, 0);

        // waiting entry: not ready, issue_done ignored, then wakes
        disp(mk(4'd7, 6'h42, 6'h13, 6'h14, 32'h0, 32'h88, 1'b0, 1'b1));
        step();
        idle();
        chk("wait_issue_ready", q.issue_ready, 0);
        chk("wait_show_entry0", q.issue_rdtag, 6'h42);
        issue_one();
        chk("ignored_done_occ", q.occupancy, 1);
        q.cdb_valid = 1'b1;
        q.cdb_tag   = 6'h13;
        q.cdb_data  = 32'h55;
        step();
        idle();
        chk("late_wake_ready", q.issue_ready, 1);
        chk("late_wake_rsdata", q.issue_rsdata, 32'h55);
        issue_one();
        chk("late_drain_occ", q.occupancy, 0);

        // flush beats dispatch and issue
        fill(6'h51, 3);
        chk("preflush_occ", q.occupancy, 3);
        q.flush      = 1'b1;
        q.issue_done = 1'b1;
        disp(mk(4'd9, 6'h54, 6'h00, 6'h00, 32'h1, 32'h2, 1'b1, 1'b1));
        step();
        idle();
        chk("flush_occ", q.occupancy, 0);
        chk("flush_issue_ready", q.issue_ready, 0);
        chk("flush_dispatch_ready", q.dispatch_ready, 1);

        // dispatch into a full queue without removal is dropped
        fill(6'h61, 4);
        q.dispatch_en      = 1'b1;
        q.dispatch_rdtag   = 6'h65;
        q.dispatch_rsvalid = 1'b1;
        q.dispatch_rtvalid = 1'b1;
        step();
        idle();
        chk("drop_occ", q.occupancy, 4);
        for (int k = 0; k < 4; k++) begin
            chk("drop_order_rdtag", q.issue_rdtag, 6'h61 + 6'(k));
            issue_one();
        end
        chk("drop_drain_occ", q.occupancy, 0);

        // reset mid-operation, overriding flush
        fill(6'h71, 2);
        reset   = 1'b1;
        q.flush = 1'b1;
        step();
        idle();
        chk("midrst_occ", q.occupancy, 0);
        chk("midrst_issue_ready", q.issue_ready, 0);
        chk("midrst_dispatch_ready", q.dispatch_ready, 1);
        chk("midrst_rdtag", q.issue_rdtag, 0);
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
